// File: rtl/jt51_mix_pkg.sv
// Shared constants for the jt51 output mixer: default widths and slot numbering.
package jt51_mix_pkg;
  localparam int unsigned ACC_W_DEF   = 19;
  localparam int unsigned OUT_W_DEF   = 16;
  localparam int unsigned OP_W        = 14;
  localparam int unsigned NOISE_W     = 11;
  localparam int unsigned SLOT_W      = 5;
  localparam int unsigned SLOT_LAST   = 31;
  localparam int unsigned SLOT_NOISE  = 31;
  localparam int unsigned NOISE_SHIFT = 3;
endpackage

// File: rtl/jt51_mix_sat.sv
// Combinational signed clamp from an ACC_W-bit sum to an OUT_W-bit sample.
module jt51_mix_sat
  import jt51_mix_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [OUT_W-1:0] dout_c
);

  // Every bit from the sign down to the output MSB must agree for the value to fit
  localparam int unsigned HI_W = ACC_W - OUT_W + 1;

  logic [HI_W-1:0] hi;
  assign hi = din[ACC_W-1:OUT_W-1];

  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (!hi[HI_W-1] && (|hi)) begin
      dout_c = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (hi[HI_W-1] && !(&hi)) begin
      dout_c = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/jt51_mix_acc.sv
// Per-frame stereo accumulator for the 32 operator slots, clamped to OUT_W at slot 31.
// Define JT51_MIX_NOISE_EN to replace the slot-31 term with the noise sample when ne is set.
module jt51_mix_acc
  import jt51_mix_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      zero,
  input  logic signed [OP_W-1:0]    op_result,
  input  logic                      op_out_en,
  input  logic [1:0]                rl,
  input  logic                      ne,
  input  logic signed [NOISE_W-1:0] noise,
  output logic signed [OUT_W-1:0]   left,
  output logic signed [OUT_W-1:0]   right,
  output logic                      sample
);

  logic [SLOT_W-1:0]       cnt;
  logic                    synced;
  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;

  logic signed [OP_W-1:0]  term_op_c;
  logic signed [ACC_W-1:0] term_c;
  logic signed [ACC_W-1:0] sum_l_c;
  logic signed [ACC_W-1:0] sum_r_c;
  logic signed [OUT_W-1:0] sat_l_c;
  logic signed [OUT_W-1:0] sat_r_c;
  logic                    last_c;

`ifdef JT51_MIX_NOISE_EN
  logic [SLOT_W-1:0] slot_c;
  assign slot_c    = zero ? '0 : cnt;
  assign term_op_c = (ne && slot_c == SLOT_W'(SLOT_NOISE))
                   ? {noise, {NOISE_SHIFT{1'b0}}} : op_result;
`else
  logic unused_noise_c;
  assign unused_noise_c = ^{ne, noise};
  assign term_op_c      = op_result;
`endif

  assign term_c = {{(ACC_W-OP_W){term_op_c[OP_W-1]}}, term_op_c};

  // A zero always starts a fresh frame, which also discards any partial sum on resync
  assign sum_l_c = (zero ? '0 : acc_l) + ((op_out_en && rl[0]) ? term_c : '0);
  assign sum_r_c = (zero ? '0 : acc_r) + ((op_out_en && rl[1]) ? term_c : '0);
  assign last_c  = synced && !zero && (cnt == SLOT_W'(SLOT_LAST));

  jt51_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (.din(sum_l_c), .dout_c(sat_l_c));
  jt51_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (.din(sum_r_c), .dout_c(sat_r_c));

  // Slot tracking, accumulation and the end-of-frame register step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      synced <= 1'b0;
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else if (cen) begin
      cnt    <= zero ? SLOT_W'(1) : cnt + SLOT_W'(1);
      sample <= last_c;
      if (zero) begin
        synced <= 1'b1;
      end
      if (last_c) begin
        left  <= sat_l_c;
        right <= sat_r_c;
        acc_l <= '0;
        acc_r <= '0;
      end else if (zero || synced) begin
        acc_l <= sum_l_c;
        acc_r <= sum_r_c;
      end
    end
  end

endmodule

// File: doc/jt51_mix_acc.md
JT51_MIX_ACC -- requirements
Module: jt51_mix_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 19, accumulator width in bits.
REQ-002 SHALL have parameter OUT_W, default 16, signed output sample width.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-005 SHALL have port cen  input  1  clock enable; state advances only when high.
REQ-006 SHALL have port zero  input  1  marks slot 0 of a 32-slot sample frame.
REQ-007 SHALL have port op_result  input  14  signed operator output for the current slot.
REQ-008 SHALL have port op_out_en  input  1  current slot is a carrier that contributes to the output.
REQ-009 SHALL have port rl  input  2  channel pan: rl[0] left enable, rl[1] right enable.
REQ-010 SHALL have port ne  input  1  noise enable for the operator 31 slot.
REQ-011 SHALL have port noise  input  11  signed noise sample from the noise generator.
REQ-012 SHALL have port left  output  OUT_W  signed left sample.
REQ-013 SHALL have port right  output  OUT_W  signed right sample.
REQ-014 SHALL have port sample  output  1  one-cen-cycle pulse when left/right update.

Function
REQ-015 SHALL keep a 5-bit slot counter: set to 1 on a cen cycle with zero=1, otherwise increment modulo 32.
REQ-016 SHALL treat the slot as 0 on a cen cycle with zero=1; otherwise the slot is the counter value.
REQ-017 SHALL select the term: noise_ext = {noise, 3'b000} when slot==31 and ne=1; else op_result.
REQ-018 SHALL sign-extend the term to ACC_W.
REQ-019 SHALL add the term to the left accumulator when op_out_en=1 and rl[0]=1.
REQ-020 SHALL add the term to the right accumulator when op_out_en=1 and rl[1]=1.
REQ-021 SHALL never overflow ACC_W=19 (32 x 2^13 bound); no intermediate saturation.
REQ-022 SHALL, on the slot-31 cen cycle, saturate each final sum (including the slot-31 term) to OUT_W signed range and register it into left/right.
REQ-023 SHALL clamp to +32767 / -32768 for OUT_W=16.
REQ-024 SHALL clear both accumulators on the same cycle as the saturate-and-register step, so that slot 0 starts from zero.
REQ-025 SHALL assert sample for exactly the one cen cycle following the update; latency from slot 31 input to valid output is 1 cen cycle.
REQ-026 SHALL treat zero=1 arriving when the counter is not 0 as a resync:
  - accumulators cleared, then the slot-0 term applied;
  - partial frame discarded;
  - no sample pulse;
  - left/right hold their previous values.
REQ-027 SHALL freeze all state, including sample, while cen=0; sample is only meaningful qualified by cen.

Reset
REQ-028 SHALL, on rst=1, immediately set the following to 0, independent of clk: slot counter, both accumulators, left, right, sample.
REQ-029 SHALL, after reset release, discard every slot until the first zero=1; no sample pulse before a full frame starting at a zero.

Configuration
REQ-030 SHALL, with JT51_MIX_NOISE_EN defined, substitute noise per REQ-017.
REQ-031 SHALL, without JT51_MIX_NOISE_EN defined:
  - ignore ne and noise;
  - always use op_result at slot 31;
  - create no noise logic.

Structure
REQ-032 SHALL take these constants from shared package jt51_mix_pkg: ACC_W default, OUT_W default, SLOT_NOISE=31, NOISE_SHIFT=3.
REQ-033 SHALL place the saturation logic in one sub-module, jt51_mix_sat (ACC_W-to-OUT_W signed clamp, combinational), instantiated twice.

Verification
REQ-034 SHALL cover: one frame, op_out_en=1 on slots 24..31 only, op_result=1000, rl=2'b11 -> left=right=8000, sample pulses once, 1 cen after slot 31.
REQ-035 SHALL cover: slots 24..31 with op_result=8191, rl=2'b01, one frame -> left=32767 (65528 clamped), right=0; with -8192 -> left=-32768.
REQ-036 SHALL cover: JT51_MIX_NOISE_EN defined, ne=1, noise=11'h100, only slot 31 enabled, op_result=5 -> left=2048; with macro undefined -> left=5.
REQ-037 SHALL cover: zero reasserted at slot 12 mid-frame -> no sample pulse, previous left/right held, next sample reflects only slots from the new zero.
REQ-038 SHALL cover: rst pulsed at slot 20 -> outputs 0 at once; the first sample occurs only after a full frame begins at the next zero.
REQ-039 SHALL cover: cen toggling 1-of-4 cycles with frame stimulus as in REQ-034 -> identical left/right values and one sample pulse per frame.
